// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory initiator: alignment check, lane/mask forming, request FSM
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re_mem,
  input  logic        we_mem,
  input  logic [63:0] alu_result_mem,
  input  logic [63:0] data_out_mem,
  input  logic [2:0]  memdata_width,
  output logic [63:0] address_cpu,
  output logic        wen_cpu,
  output logic [63:0] wdata_cpu,
  output logic [7:0]  wmask_cpu,
  output logic        mem_valid,
  input  logic        mem_ready,
  input  logic        resp_valid,
  input  logic [63:0] resp_rdata,
  output logic [63:0] data_in_mem,
  output logic        stall_mem,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    wmask_q, wmask_d;
  logic [63:0]   din_q, din_d;
  logic          berr_q, berr_d;

  logic          op;
  logic [2:0]    off;
  logic          aligned;
  logic [7:0]    lane_mask;
  logic [63:0]   lane_data;

  // Decode access size: alignment requirement and byte mask of the access
  always_comb begin
    op        = re_mem | we_mem;
    off       = alu_result_mem[2:0];
    aligned   = 1'b1;
    lane_mask = 8'h00;
    lane_data = data_out_mem << {off, 3'b000};
    case (memdata_width)
      3'b000, 3'b100: begin
        aligned   = 1'b1;
        lane_mask = 8'h01 << off;
      end
      3'b001, 3'b101: begin
        aligned   = (off[0] == 1'b0);
        lane_mask = 8'h03 << off;
      end
      3'b010, 3'b110: begin
        aligned   = (off[1:0] == 2'b00);
        lane_mask = 8'h0F << off;
      end
      default: begin
        // 011 and the unused 111 encoding both behave as doubleword
        aligned   = (off == 3'b000);
        lane_mask = 8'hFF;
      end
    endcase
  end

  // Next-state logic: request sequencing, timeout counting and response capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    din_d   = din_q;
    berr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (op && aligned) begin
          // A simultaneous load+store is handled as a store
          addr_d  = {alu_result_mem[63:3], 3'b000};
          wen_d   = we_mem;
          wdata_d = we_mem ? lane_data : 64'd0;
          wmask_d = we_mem ? lane_mask : 8'h00;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = '0;
        if (mem_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A response arriving on the last allowed cycle still beats the timeout
        if (resp_valid) begin
          if (!wen_q) begin
            din_d = resp_rdata;
          end
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          berr_d  = 1'b1;
          din_d   = 64'd0;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers; reset abandons any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= 64'd0;
      wen_q   <= 1'b0;
      wdata_q <= 64'd0;
      wmask_q <= 8'h00;
      din_q   <= 64'd0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      din_q   <= din_d;
      berr_q  <= berr_d;
    end
  end

  // Outputs: stall is combinational so the issue cycle already holds the pipeline
  always_comb begin
    address_cpu  = addr_q;
    wen_cpu      = wen_q;
    wdata_cpu    = wdata_q;
    wmask_cpu    = wmask_q;
    data_in_mem  = din_q;
    bus_err      = berr_q;
    mem_valid    = (state_q == REQ);
    misalign_err = (state_q == IDLE) && op && !aligned;
    stall_mem    = ((state_q == IDLE) && op && aligned) || (state_q == REQ) || (state_q == WAIT);
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        re_mem, we_mem;
  logic [63:0] alu_result_mem, data_out_mem;
  logic [2:0]  memdata_width;
  logic [63:0] address_cpu;
  logic        wen_cpu;
  logic [63:0] wdata_cpu;
  logic [7:0]  wmask_cpu;
  logic        mem_valid, mem_ready, resp_valid;
  logic [63:0] resp_rdata, data_in_mem;
  logic        stall_mem, misalign_err, bus_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  req_t        req_q[$];
  logic [63:0] din_q[$];

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .re_mem(re_mem), .we_mem(we_mem),
    .alu_result_mem(alu_result_mem), .data_out_mem(data_out_mem),
    .memdata_width(memdata_width),
    .address_cpu(address_cpu), .wen_cpu(wen_cpu),
    .wdata_cpu(wdata_cpu), .wmask_cpu(wmask_cpu),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .data_in_mem(data_in_mem), .stall_mem(stall_mem),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    re_mem = 1'b0; we_mem = 1'b0;
    alu_result_mem = 64'd0; data_out_mem = 64'd0;
    memdata_width = 3'b000;
  endtask

  task automatic run_op(input string tag, input logic re, input logic we,
                        input logic [2:0] w, input logic [63:0] addr, input logic [63:0] data,
                        input logic [63:0] e_addr, input logic e_wen,
                        input logic [63:0] e_wdata, input logic [7:0] e_mask,
                        input int ready_wait, input int resp_wait, input bit give_resp,
                        input logic [63:0] rdata, input logic [63:0] e_din, input logic e_berr,
                        input int e_stalls, input int e_valids);
    req_t r;
    int   stalls, valids, wc;
    bit   hs, in_wait, done;
    logic [63:0] exp_din;
    @(negedge clk);
    re_mem = re; we_mem = we; memdata_width = w;
    alu_result_mem = addr; data_out_mem = data;
    r.addr = e_addr; r.wen = e_wen; r.wdata = e_wdata; r.wmask = e_mask;
    req_q.push_back(r);
    din_q.push_back(e_din);
    #1;
    chk({tag, "_issue_misalign"}, misalign_err, 1'b0);
    stalls = 0; valids = 0; wc = 0; hs = 0; in_wait = 0; done = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (hs) begin in_wait = 1; hs = 0; end
      if (!stall_mem) begin done = 1; break; end
      stalls++;
      chk({tag, "_bus_err_busy"}, bus_err, 1'b0);
      if (mem_valid) begin
        valids++;
        if (req_q.size() > 0) begin
          chk({tag, "_address_cpu"}, address_cpu, req_q[0].addr);
          chk({tag, "_wen_cpu"}, wen_cpu, req_q[0].wen);
          chk({tag, "_wdata_cpu"}, wdata_cpu, req_q[0].wdata);
          chk({tag, "_wmask_cpu"}, wmask_cpu, req_q[0].wmask);
        end
        if (valids > ready_wait) begin
          mem_ready = 1'b1;
          hs = 1;
          if (req_q.size() > 0) void'(req_q.pop_front());
        end
      end
      if (in_wait) begin
        if (give_resp && wc == resp_wait) begin
          resp_valid = 1'b1;
          resp_rdata = rdata;
        end
        wc++;
      end
      @(negedge clk);
      mem_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
    end
    chk({tag, "_done_reached"}, done, 1'b1);
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'(e_stalls));
    chk({tag, "_valid_cycles"}, 64'(valids), 64'(e_valids));
    chk({tag, "_done_mem_valid"}, mem_valid, 1'b0);
    exp_din = (din_q.size() > 0) ? din_q.pop_front() : 64'hx;
    chk({tag, "_data_in_mem"}, data_in_mem, exp_din);
    chk({tag, "_done_bus_err"}, bus_err, e_berr);
    idle_inputs();
    @(negedge clk); #1;
    chk({tag, "_after_bus_err"}, bus_err, 1'b0);
    chk({tag, "_after_stall"}, stall_mem, 1'b0);
    chk({tag, "_after_data_hold"}, data_in_mem, exp_din);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    mem_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 64'd0;
    @(negedge clk); #1;
    chk("reset_mem_valid", mem_valid, 1'b0);
    chk("reset_stall", stall_mem, 1'b0);
    chk("reset_address", address_cpu, 64'd0);
    chk("reset_wen", wen_cpu, 1'b0);
    chk("reset_wdata", wdata_cpu, 64'd0);
    chk("reset_wmask", wmask_cpu, 8'h00);
    chk("reset_din", data_in_mem, 64'd0);
    chk("reset_bus_err", bus_err, 1'b0);
    chk("reset_misalign", misalign_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // ld with two REQ cycles of backpressure
    run_op("ld", 1'b1, 1'b0, 3'b011, 64'h2000, 64'd0,
           64'h2000, 1'b0, 64'd0, 8'h00,
           2, 0, 1'b1, 64'h1122334455667788, 64'h1122334455667788, 1'b0, 5, 3);

    // sb: write response data must not be captured
    run_op("sb", 1'b0, 1'b1, 3'b000, 64'h1003, 64'hAB,
           64'h1000, 1'b1, 64'h00000000AB000000, 8'h08,
           0, 0, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'h1122334455667788, 1'b0, 3, 1);

    // misaligned sw then misaligned ld
    @(negedge clk);
    we_mem = 1'b1; memdata_width = 3'b010; alu_result_mem = 64'h1002; data_out_mem = 64'h55;
    #1;
    chk("sw_mis_err", misalign_err, 1'b1);
    chk("sw_mis_stall", stall_mem, 1'b0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("sw_mis_pulse_end", misalign_err, 1'b0);
    chk("sw_mis_no_valid", mem_valid, 1'b0);
    re_mem = 1'b1; memdata_width = 3'b011; alu_result_mem = 64'h2004;
    #1;
    chk("ld_mis_err", misalign_err, 1'b1);
    chk("ld_mis_stall", stall_mem, 1'b0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("ld_mis_no_valid", mem_valid, 1'b0);
    chk("ld_mis_din_hold", data_in_mem, 64'h1122334455667788);

    // sh into the top halfword, two-cycle response latency
    run_op("sh", 1'b0, 1'b1, 3'b001, 64'h3006, 64'hBEEF,
           64'h3000, 1'b1, 64'hBEEF000000000000, 8'hC0,
           0, 2, 1'b1, 64'd0, 64'h1122334455667788, 1'b0, 5, 1);

    // re and we together behave as a store
    run_op("sd_both", 1'b1, 1'b1, 3'b011, 64'h0008, 64'h0102030405060708,
           64'h0008, 1'b1, 64'h0102030405060708, 8'hFF,
           0, 0, 1'b1, 64'h0, 64'h1122334455667788, 1'b0, 3, 1);

    // lw with no response: four WAIT cycles then bus_err
    run_op("timeout", 1'b1, 1'b0, 3'b010, 64'h400C, 64'd0,
           64'h4008, 1'b0, 64'd0, 8'h00,
           0, 0, 1'b0, 64'd0, 64'd0, 1'b1, 6, 1);

    // response on the final WAIT cycle beats the timeout
    run_op("resp_wins", 1'b1, 1'b0, 3'b011, 64'h4010, 64'd0,
           64'h4010, 1'b0, 64'd0, 8'h00,
           0, 3, 1'b1, 64'hCAFE_F00D_1234_5678, 64'hCAFE_F00D_1234_5678, 1'b0, 6, 1);

    // reset in REQ: asynchronous drop, late response ignored
    @(negedge clk);
    re_mem = 1'b1; memdata_width = 3'b011; alu_result_mem = 64'h5000;
    @(negedge clk); #1;
    chk("rst_req_valid", mem_valid, 1'b1);
    #2;
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("rst_async_valid", mem_valid, 1'b0);
    chk("rst_async_stall", stall_mem, 1'b0);
    chk("rst_async_addr", address_cpu, 64'd0);
    chk("rst_async_din", data_in_mem, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    resp_valid = 1'b1; resp_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    @(negedge clk);
    resp_valid = 1'b0;
    #1;
    chk("rst_late_resp_din", data_in_mem, 64'd0);
    chk("rst_late_resp_stall", stall_mem, 1'b0);
    chk("rst_late_resp_valid", mem_valid, 1'b0);
    chk("rst_late_resp_berr", bus_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
